// File: rtl/ex_mem_stage.sv
// EX->MEM elastic pipeline register with valid/ready handshake.
// Optional one-entry skid buffer keeps in_ready off the MEM ready path.
module ex_mem_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned REG_AW  = 5,
    parameter bit          SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              MemtoReg_ex,
    input  logic              RegWrite_ex,
    input  logic              MemWrite_ex,
    input  logic [DATA_W-1:0] ALUResult_ex,
    input  logic [DATA_W-1:0] MemWriteData_ex,
    input  logic [REG_AW-1:0] rdAddr_ex,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              MemtoReg_mem,
    output logic              RegWrite_mem,
    output logic              MemWrite_mem,
    output logic [DATA_W-1:0] ALUResult_mem,
    output logic [DATA_W-1:0] MemWriteData_mem,
    output logic [REG_AW-1:0] rdAddr_mem
);

    typedef struct packed {
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_write;
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] mem_wdata;
        logic [REG_AW-1:0] rd_addr;
    } entry_t;

    entry_t in_entry;
    entry_t out_q;
    entry_t out_d;
    entry_t skid_q;
    entry_t skid_d;
    logic   out_valid_q;
    logic   out_valid_d;
    logic   skid_valid_q;
    logic   skid_valid_d;
    logic   in_fire;
    logic   out_load;

    always_comb begin
        in_entry            = '0;
        in_entry.mem_to_reg = MemtoReg_ex;
        in_entry.reg_write  = RegWrite_ex;
        in_entry.mem_write  = MemWrite_ex;
        in_entry.alu_result = ALUResult_ex;
        in_entry.mem_wdata  = MemWriteData_ex;
        in_entry.rd_addr    = rdAddr_ex;
    end

    // rst forces in_ready high so EX sees a ready stage from the first cycle.
    always_comb begin
        if (SKID_EN) begin
            in_ready = rst | ~skid_valid_q;
        end else begin
            in_ready = rst | ~out_valid_q | out_ready;
        end
    end

    assign in_fire  = in_valid & in_ready;
    assign out_load = ~out_valid_q | out_ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_load) begin
            // A full skid means in_ready is low, so no in_fire competes here.
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = in_fire;
                if (in_fire) begin
                    out_d = in_entry;
                end
            end
        end else if (in_fire && SKID_EN) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign MemtoReg_mem     = out_q.mem_to_reg;
    assign RegWrite_mem     = out_q.reg_write & out_valid_q;
    assign MemWrite_mem     = out_q.mem_write & out_valid_q;
    assign ALUResult_mem    = out_q.alu_result;
    assign MemWriteData_mem = out_q.mem_wdata;
    assign rdAddr_mem       = out_q.rd_addr;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed skid/flush/reset scenarios plus
// queue-model checking for the no-skid and wide randomized configurations.
`timescale 1ns/1ps
module tb_ex_mem_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic flush;

  int errors = 0;
  int checks = 0;

  logic        a_in_valid, a_in_ready, a_mtr, a_rw, a_mw;
  logic [31:0] a_alu, a_wd;
  logic [4:0]  a_rd;
  logic        a_out_valid, a_out_ready, a_mtr_m, a_rw_m, a_mw_m;
  logic [31:0] a_alu_m, a_wd_m;
  logic [4:0]  a_rd_m;
  logic [72:0] a_obs;

  logic        n_in_valid, n_in_ready, n_mtr, n_rw, n_mw;
  logic [31:0] n_alu, n_wd;
  logic [4:0]  n_rd;
  logic        n_out_valid, n_out_ready, n_mtr_m, n_rw_m, n_mw_m;
  logic [31:0] n_alu_m, n_wd_m;
  logic [4:0]  n_rd_m;

  logic        w_in_valid, w_in_ready, w_mtr, w_rw, w_mw;
  logic [63:0] w_alu, w_wd;
  logic [5:0]  w_rd;
  logic        w_out_valid, w_out_ready, w_mtr_m, w_rw_m, w_mw_m;
  logic [63:0] w_alu_m, w_wd_m;
  logic [5:0]  w_rd_m;

  typedef struct packed {
    logic        mtr;
    logic        rw;
    logic        mw;
    logic [63:0] alu;
    logic [63:0] wd;
    logic [5:0]  rd;
  } went_t;

  ex_mem_stage dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .MemtoReg_ex(a_mtr), .RegWrite_ex(a_rw),
    .MemWrite_ex(a_mw),
    .ALUResult_ex(a_alu), .MemWriteData_ex(a_wd),
    .rdAddr_ex(a_rd),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .MemtoReg_mem(a_mtr_m), .RegWrite_mem(a_rw_m),
    .MemWrite_mem(a_mw_m),
    .ALUResult_mem(a_alu_m), .MemWriteData_mem(a_wd_m),
    .rdAddr_mem(a_rd_m)
  );

  ex_mem_stage #(
    .DATA_W(32), .REG_AW(5), .SKID_EN(1'b0)
  ) dut_n (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready),
    .MemtoReg_ex(n_mtr), .RegWrite_ex(n_rw),
    .MemWrite_ex(n_mw),
    .ALUResult_ex(n_alu), .MemWriteData_ex(n_wd),
    .rdAddr_ex(n_rd),
    .out_valid(n_out_valid), .out_ready(n_out_ready),
    .MemtoReg_mem(n_mtr_m), .RegWrite_mem(n_rw_m),
    .MemWrite_mem(n_mw_m),
    .ALUResult_mem(n_alu_m), .MemWriteData_mem(n_wd_m),
    .rdAddr_mem(n_rd_m)
  );

  ex_mem_stage #(
    .DATA_W(64), .REG_AW(6), .SKID_EN(1'b1)
  ) dut_w (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(w_in_valid), .in_ready(w_in_ready),
    .MemtoReg_ex(w_mtr), .RegWrite_ex(w_rw),
    .MemWrite_ex(w_mw),
    .ALUResult_ex(w_alu), .MemWriteData_ex(w_wd),
    .rdAddr_ex(w_rd),
    .out_valid(w_out_valid), .out_ready(w_out_ready),
    .MemtoReg_mem(w_mtr_m), .RegWrite_mem(w_rw_m),
    .MemWrite_mem(w_mw_m),
    .ALUResult_mem(w_alu_m), .MemWriteData_mem(w_wd_m),
    .rdAddr_mem(w_rd_m)
  );

  always_comb a_obs = {a_out_valid, a_mtr_m, a_rw_m,
                       a_mw_m, a_alu_m, a_wd_m, a_rd_m};

  function automatic logic [72:0] exp_a(
    input logic v, input logic [2:0] ctl,
    input logic [31:0] alu, input logic [4:0] rd);
    return {v, ctl[2], ctl[1] & v, ctl[0] & v,
            alu, ~alu, rd};
  endfunction

  task automatic a_drive(
    input logic v, input logic ordy,
    input logic [2:0] ctl,
    input logic [31:0] alu, input logic [4:0] rd);
    a_in_valid  = v;
    a_out_ready = ordy;
    a_mtr       = ctl[2];
    a_rw        = ctl[1];
    a_mw        = ctl[0];
    a_alu       = alu;
    a_wd        = ~alu;
    a_rd        = rd;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (a_obs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", a_obs);
    end
    checks++;
    if (a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready_during_rst: got %b",
               a_in_ready);
    end
    checks++;
    if ({n_out_valid, w_out_valid, w_alu_m} !== '0) begin
      errors++;
      $display("FAIL reset_other_instances: %b%b %h",
               n_out_valid, w_out_valid, w_alu_m);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (a_in_ready !== 1'b1 || a_obs !== '0) begin
      errors++;
      $display("FAIL reset_release: rdy %b outs %h",
               a_in_ready, a_obs);
    end
  endtask

  task automatic test_back_to_back;
    int          nvalid;
    logic [2:0]  c;
    logic [72:0] e;
    nvalid = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      c = (k == 2) ? 3'b000 : 3'b110;
      if (k < 4)
        a_drive(1'b1, 1'b1, c, 32'(16 * (k + 1)),
                5'(k + 1));
      else
        a_drive(1'b0, 1'b1, 3'b000, 32'h0, 5'h0);
      #1;
      if (k == 0)
        e = '0;
      else if (k <= 4)
        e = exp_a(1'b1, (k == 3) ? 3'b000 : 3'b110,
                  32'(16 * k), 5'(k));
      else
        e = exp_a(1'b0, 3'b110, 32'h40, 5'd4);
      checks++;
      if (a_obs !== e) begin
        errors++;
        $display("FAIL b2b_out[%0d]: got %h want %h",
                 k, a_obs, e);
      end
      checks++;
      if (a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b",
                 k, a_in_ready);
      end
      if (a_out_valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 4) begin
      errors++;
      $display("FAIL b2b_valid_cycles: got %0d want 4",
               nvalid);
    end
  endtask

  task automatic test_skid;
    logic [31:0] va, vb, vc;
    va = 32'hA000_0001;
    vb = 32'hB000_0002;
    vc = 32'hC000_0003;
    @(negedge clk);
    a_drive(1'b1, 1'b0, 3'b111, va, 5'd10);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 3'b010, vb, 5'd11);
    #1;
    checks++;
    if (a_obs !== exp_a(1'b1, 3'b111, va, 5'd10) ||
        a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_a_out: got %h rdy %b",
               a_obs, a_in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_drive(1'b1, (i == 2), 3'b001, vc, 5'd12);
      #1;
      checks++;
      if (a_obs !== exp_a(1'b1, 3'b111, va, 5'd10) ||
          a_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL skid_full_hold[%0d]: got %h rdy %b",
                 i, a_obs, a_in_ready);
      end
    end
    @(negedge clk);
    a_drive(1'b1, 1'b1, 3'b001, vc, 5'd12);
    #1;
    checks++;
    if (a_obs !== exp_a(1'b1, 3'b010, vb, 5'd11) ||
        a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL skid_drain_b: got %h rdy %b",
               a_obs, a_in_ready);
    end
    @(negedge clk);
    a_drive(1'b0, 1'b1, 3'b000, 32'h0, 5'd0);
    #1;
    checks++;
    if (a_obs !== exp_a(1'b1, 3'b001, vc, 5'd12)) begin
      errors++;
      $display("FAIL skid_then_c: got %h", a_obs);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_obs !== exp_a(1'b0, 3'b001, vc, 5'd12)) begin
      errors++;
      $display("FAIL skid_idle_keep: got %h", a_obs);
    end
  endtask

  task automatic test_flush;
    logic [31:0] va, vb;
    logic [72:0] e;
    va = 32'h1111_0000;
    vb = 32'h2222_0000;
    e  = exp_a(1'b0, 3'b111, va, 5'd1);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 3'b111, va, 5'd1);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 3'b011, vb, 5'd2);
    @(negedge clk);
    a_drive(1'b0, 1'b0, 3'b000, 32'h0, 5'd0);
    flush = 1'b1;
    #1;
    checks++;
    if (a_obs !== exp_a(1'b1, 3'b111, va, 5'd1) ||
        a_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_pre: got %h rdy %b",
               a_obs, a_in_ready);
    end
    @(negedge clk);
    a_drive(1'b1, 1'b1, 3'b111, 32'h3333_0000, 5'd3);
    #1;
    checks++;
    if (a_obs !== e || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_squash: got %h rdy %b want %h",
               a_obs, a_in_ready, e);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      flush = 1'b0;
      a_drive(1'b0, 1'b1, 3'b000, 32'h0, 5'd0);
      #1;
      checks++;
      if (a_obs !== e || a_in_ready !== 1'b1) begin
        errors++;
        $display("FAIL flush_after[%0d]: got %h rdy %b",
                 i, a_obs, a_in_ready);
      end
    end
  endtask

  task automatic test_rst_held;
    logic [72:0] e0, e1, e2;
    e0 = exp_a(1'b1, 3'b111, 32'h4444_0000, 5'd7);
    e1 = exp_a(1'b1, 3'b110, 32'hDEAD_BEEF, 5'd5);
    e2 = exp_a(1'b0, 3'b110, 32'hDEAD_BEEF, 5'd5);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 3'b111, 32'h4444_0000, 5'd7);
    @(negedge clk);
    a_drive(1'b1, 1'b0, 3'b110, 32'h5555_0000, 5'd8);
    @(negedge clk);
    a_drive(1'b0, 1'b0, 3'b000, 32'h0, 5'd0);
    rst = 1'b1;
    #1;
    checks++;
    if (a_obs !== e0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_held_pre: got %h rdy %b",
               a_obs, a_in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    a_drive(1'b1, 1'b1, 3'b110, 32'hDEAD_BEEF, 5'd5);
    #1;
    checks++;
    if (a_obs !== '0 || a_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_held_clear: got %h rdy %b",
               a_obs, a_in_ready);
    end
    @(negedge clk);
    a_drive(1'b0, 1'b1, 3'b000, 32'h0, 5'd0);
    #1;
    checks++;
    if (a_obs !== e1) begin
      errors++;
      $display("FAIL rst_first_entry: got %h want %h",
               a_obs, e1);
    end
    @(negedge clk);
    #1;
    checks++;
    if (a_obs !== e2) begin
      errors++;
      $display("FAIL rst_entry_once: got %h want %h",
               a_obs, e2);
    end
  endtask

  task automatic test_no_skid;
    int   q[$];
    int   sent, consumed;
    logic ev, er;
    sent = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 40 && consumed < 8; cyc++) begin
      @(negedge clk);
      n_out_ready = (cyc % 2 == 0);
      n_in_valid  = (sent < 8);
      n_alu       = 32'(sent + 1);
      n_wd        = ~n_alu;
      n_rd        = 5'(sent + 1);
      #1;
      ev = (q.size() > 0);
      er = ~ev | n_out_ready;
      checks++;
      if (n_in_ready !== er) begin
        errors++;
        $display("FAIL noskid_in_ready[%0d]: got %b want %b",
                 cyc, n_in_ready, er);
      end
      checks++;
      if (n_out_valid !== ev) begin
        errors++;
        $display("FAIL noskid_out_valid[%0d]: got %b want %b",
                 cyc, n_out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (n_alu_m !== 32'(q[0]) ||
            n_wd_m !== ~32'(q[0]) ||
            n_rd_m !== 5'(q[0]) ||
            n_rw_m !== 1'b1 || n_mw_m !== 1'b0) begin
          errors++;
          $display("FAIL noskid_data[%0d]: got %h/%h want %h",
                   cyc, n_alu_m, n_rd_m, q[0]);
        end
      end
      if (ev && n_out_ready) begin
        void'(q.pop_front());
        consumed++;
      end
      if (n_in_valid && er) begin
        q.push_back(sent + 1);
        sent++;
      end
    end
    checks++;
    if (consumed != 8 || q.size() != 0) begin
      errors++;
      $display("FAIL noskid_count: got %0d want 8",
               consumed);
    end
    @(negedge clk);
    n_in_valid  = 1'b0;
    n_out_ready = 1'b1;
  endtask

  task automatic test_stress;
    went_t q[$];
    went_t last;
    went_t cur;
    int    occ, popped;
    logic  er;
    last   = '0;
    popped = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      @(negedge clk);
      w_in_valid  = ($urandom_range(0, 99) < 60);
      w_out_ready = ($urandom_range(0, 99) < 65);
      flush       = ($urandom_range(0, 299) == 0);
      cur.mtr = 1'($urandom);
      cur.rw  = 1'($urandom);
      cur.mw  = 1'($urandom);
      cur.alu = {$urandom, $urandom};
      cur.wd  = {$urandom, $urandom};
      cur.rd  = 6'($urandom);
      w_mtr = cur.mtr;
      w_rw  = cur.rw;
      w_mw  = cur.mw;
      w_alu = cur.alu;
      w_wd  = cur.wd;
      w_rd  = cur.rd;
      #1;
      occ = q.size();
      if (occ > 0) last = q[0];
      er = (occ < 2);
      checks++;
      if (w_in_ready !== er) begin
        errors++;
        $display("FAIL stress_in_ready[%0d]: got %b want %b",
                 cyc, w_in_ready, er);
      end
      checks++;
      if (w_out_valid !== (occ > 0)) begin
        errors++;
        $display("FAIL stress_out_valid[%0d]: got %b",
                 cyc, w_out_valid);
      end
      checks++;
      if ({w_mtr_m, w_rw_m, w_mw_m,
           w_alu_m, w_wd_m, w_rd_m} !==
          {last.mtr, last.rw & (occ > 0),
           last.mw & (occ > 0),
           last.alu, last.wd, last.rd}) begin
        errors++;
        $display("FAIL stress_data[%0d]: got %h %h want %h %h",
                 cyc, w_alu_m, w_rd_m, last.alu, last.rd);
      end
      checks++;
      if (w_out_valid === 1'b0 && w_mw_m !== 1'b0) begin
        errors++;
        $display("FAIL stress_mw_gate[%0d]: got %b",
                 cyc, w_mw_m);
      end
      if (flush) begin
        q.delete();
      end else begin
        if (occ > 0 && w_out_ready) begin
          void'(q.pop_front());
          popped++;
        end
        if (w_in_valid && er) q.push_back(cur);
      end
    end
    @(negedge clk);
    flush      = 1'b0;
    w_in_valid = 1'b0;
    checks++;
    if (popped < 1000) begin
      errors++;
      $display("FAIL stress_traffic: got %0d want >= 1000",
               popped);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    a_drive(1'b0, 1'b1, 3'b000, 32'h0, 5'd0);
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    n_mtr = 1'b0; n_rw = 1'b1; n_mw = 1'b0;
    n_alu = '0; n_wd = '0; n_rd = '0;
    w_in_valid = 1'b0; w_out_ready = 1'b1;
    w_mtr = 1'b0; w_rw = 1'b0; w_mw = 1'b0;
    w_alu = '0; w_wd = '0; w_rd = '0;
    test_reset();
    test_back_to_back();
    test_skid();
    test_flush();
    test_rst_held();
    test_no_skid();
    test_stress();
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
